// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: host time-set request/acknowledge bundle
//   set_req  : host request level (4-phase)
//   set_sec/set_min/set_hour/set_day : requested time, stable while set_req=1
//   set_ack  : acknowledge, held while set_req stays high
//   set_err  : 1 = request rejected, valid with set_ack
interface rtc_timekeeper_if #(parameter int DAY_W = 16);
    logic             set_req;
    logic [5:0]       set_sec;
    logic [5:0]       set_min;
    logic [4:0]       set_hour;
    logic [DAY_W-1:0] set_day;
    logic             set_ack;
    logic             set_err;
    modport master (output set_req, set_sec, set_min, set_hour, set_day, input set_ack, set_err);
    modport slave  (input set_req, set_sec, set_min, set_hour, set_day, output set_ack, set_err);
endinterface

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: time-of-day counters, host time-set sequencer and alarm match
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : 1 Hz one-cycle pulse from the divider
//   bus         : host time-set handshake (slave side)
//   alarm_en, alarm_sec/min/hour : live alarm compare inputs
//   alarm       : one-cycle pulse when a tick lands on the alarm time
//   sec/min/hour/day : current time, registered
module rtc_timekeeper #(
    parameter int DAY_W     = 16,
    parameter int HOURS_DAY = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    rtc_timekeeper_if.slave  bus,
    input  logic             alarm_en,
    input  logic [5:0]       alarm_sec,
    input  logic [5:0]       alarm_min,
    input  logic [4:0]       alarm_hour,
    output logic             alarm,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hour,
    output logic [DAY_W-1:0] day
);
    typedef enum logic [1:0] {IDLE, CHECK, APPLY, ACK} state_t;
    state_t           state, state_nx;
    logic             legal, err_q;
    logic [5:0]       ld_sec, ld_min;
    logic [4:0]       ld_hour;
    logic [DAY_W-1:0] ld_day;
    logic             sec_w, min_w, hour_w;
    logic [5:0]       sec_nx, min_nx;
    logic [4:0]       hour_nx;
    logic [DAY_W-1:0] day_nx;

    assign legal = bus.set_sec < 6'd60 && bus.set_min < 6'd60 && {1'b0, bus.set_hour} < 6'(HOURS_DAY);

    // whole carry chain resolves combinationally so a rollover takes one tick
    assign sec_w   = sec == 6'd59;
    assign min_w   = min == 6'd59;
    assign hour_w  = hour == 5'(HOURS_DAY - 1);
    assign sec_nx  = sec_w ? '0 : sec + 6'd1;
    assign min_nx  = !sec_w ? min : min_w ? '0 : min + 6'd1;
    assign hour_nx = !(sec_w && min_w) ? hour : hour_w ? '0 : hour + 5'd1;
    assign day_nx  = day + DAY_W'(sec_w && min_w && hour_w);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = bus.set_req ? CHECK : IDLE;
            CHECK: state_nx = legal ? APPLY : ACK;
            APPLY: state_nx = ACK;
            ACK:   state_nx = bus.set_req ? ACK : IDLE;
        endcase
    end

    always_comb begin
        bus.set_ack = state == ACK;
        bus.set_err = state == ACK && err_q;
    end

    // a tick during APPLY is dropped: the loaded value wins and no alarm is raised
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ld_sec  <= '0;
            ld_min  <= '0;
            ld_hour <= '0;
            ld_day  <= '0;
            err_q   <= 1'b0;
            sec     <= '0;
            min     <= '0;
            hour    <= '0;
            day     <= '0;
            alarm   <= 1'b0;
        end else begin
            if (state == CHECK) begin
                ld_sec  <= bus.set_sec;
                ld_min  <= bus.set_min;
                ld_hour <= bus.set_hour;
                ld_day  <= bus.set_day;
                err_q   <= !legal;
            end
            if (state == APPLY) begin
                sec  <= ld_sec;
                min  <= ld_min;
                hour <= ld_hour;
                day  <= ld_day;
            end else if (tick) begin
                sec  <= sec_nx;
                min  <= min_nx;
                hour <= hour_nx;
                day  <= day_nx;
            end
            alarm <= tick && alarm_en && state != APPLY &&
                     {hour_nx, min_nx, sec_nx} == {alarm_hour, alarm_min, alarm_sec};
        end
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: scoreboard bench for rtc_timekeeper (main DAY_W=16 instance, DAY_W=4 wrap instance)
module tb_rtc_timekeeper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        alarm_en;
    logic [5:0]  alarm_sec, alarm_min;
    logic [4:0]  alarm_hour;
    logic        alarm, alarm4;
    logic [5:0]  sec, min, sec4, min4;
    logic [4:0]  hour, hour4;
    logic [15:0] day;
    logic [3:0]  day4;
    logic [3:0]  zero4 = 4'd0;
    int          checks = 0;
    int          errors = 0;
    int          tod = 0;
    int          dayv = 0;

    typedef struct { string tag; logic [63:0] val; } exp_t;
    exp_t sb[$];

    rtc_timekeeper_if #(.DAY_W(16)) bus ();
    rtc_timekeeper_if #(.DAY_W(4))  bus4 ();

    rtc_timekeeper #(.DAY_W(16), .HOURS_DAY(24)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus),
        .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
        .alarm(alarm), .sec(sec), .min(min), .hour(hour), .day(day));

    rtc_timekeeper #(.DAY_W(4), .HOURS_DAY(24)) dut4 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus4),
        .alarm_en(1'b0), .alarm_sec(6'd0), .alarm_min(6'd0), .alarm_hour(5'd0),
        .alarm(alarm4), .sec(sec4), .min(min4), .hour(hour4), .day(day4));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [63:0] now_time();
        return 64'({day, hour, min, sec});
    endfunction

    function automatic logic [63:0] model_now();
        logic [15:0] d = dayv[15:0];
        return 64'({d, 5'(tod / 3600), 6'((tod / 60) % 60), 6'(tod % 60)});
    endfunction

    task automatic model_tick();
        tod = (tod + 1) % 86400;
        if (tod == 0) dayv = (dayv + 1) % 65536;
    endtask

    task automatic do_tick();
        model_tick();
        sb_push("tick_time", model_now());
        sb_push("tick_alarm", 64'(alarm_en && tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60 + int'(alarm_sec)));
        tick = 1'b1;
        step();
        tick = 1'b0;
        sb_pop(now_time());
        sb_pop(64'(alarm));
        step();
        chk("alarm_1cyc", 64'(alarm), 64'd0);
    endtask

    // tph: cycle after set_req rises in which to inject a tick (1=CHECK, 2=APPLY, 0=none)
    task automatic host_set(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                            input logic [15:0] d, input int tph);
        logic legal = s < 60 && m < 60 && h < 24;
        bit   got = 0;
        int   lat = 0;
        sb_push("ack_lat", legal ? 64'd3 : 64'd2);
        sb_push("ack_err", 64'(!legal));
        bus.set_sec = s; bus.set_min = m; bus.set_hour = h; bus.set_day = d;
        bus.set_req = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            tick = tph != 0 && c == tph;
            step();
            if (tick && c == 1) begin
                model_tick();
                chk("check_tick", now_time(), model_now());
            end
            tick = 1'b0;
            if (bus.set_ack) begin
                got = 1;
                lat = c + 1;
            end
        end
        sb_pop(64'(lat));
        sb_pop(64'(bus.set_err));
        if (legal) tod = int'(h) * 3600 + int'(m) * 60 + int'(s);
        if (legal) dayv = int'(d);
        chk("set_time", now_time(), model_now());
        chk("set_noalarm", 64'(alarm), 64'd0);
        step();
        chk("ack_hold", 64'({bus.set_ack, bus.set_err}), 64'({1'b1, !legal}));
        bus.set_req = 1'b0;
        step();
        chk("ack_drop", 64'({bus.set_ack, bus.set_err}), 64'd0);
        chk("time_held", now_time(), model_now());
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        tick = 1'b0;
        alarm_en = 1'b0;
        alarm_sec = '0; alarm_min = '0; alarm_hour = '0;
        bus.set_req = 1'b0; bus.set_sec = '0; bus.set_min = '0; bus.set_hour = '0; bus.set_day = '0;
        bus4.set_req = 1'b0; bus4.set_sec = '0; bus4.set_min = '0; bus4.set_hour = '0; bus4.set_day = '0;
        repeat (3) step();
        chk("rst_out", 64'({alarm, bus.set_ack, bus.set_err, day, hour, min, sec}), 64'd0);
        rst_n = 1'b1;
        step();
        repeat (3) do_tick();
        // async reset mid-count with a set request in flight
        bus.set_sec = 6'd30; bus.set_min = 6'd30; bus.set_hour = 5'd3; bus.set_day = 16'd9;
        bus.set_req = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({alarm, bus.set_ack, bus.set_err, day, hour, min, sec}), 64'd0);
        tod = 0;
        dayv = 0;
        bus.set_req = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("rst_no_ack", 64'({bus.set_ack, now_time()}), 64'd0);
        end
        repeat (5) do_tick();
        chk("sec5", 64'(sec), 64'd5);

        host_set(6'd58, 6'd59, 5'd23, 16'd7, 0);
        do_tick();
        do_tick();
        chk("rollover", now_time(), 64'({16'd8, 5'd0, 6'd0, 6'd0}));

        host_set(6'd56, 6'd34, 5'd12, 16'd3, 0);
        repeat (3) step();
        chk("set_stable", now_time(), model_now());
        do_tick();

        host_set(6'd60, 6'd10, 5'd1, 16'd44, 0);
        host_set(6'd1, 6'd60, 5'd1, 16'd44, 0);
        host_set(6'd1, 6'd1, 5'd24, 16'd44, 0);
        do_tick();

        host_set(6'd10, 6'd20, 5'd5, 16'd100, 2);
        chk("apply_tick", now_time(), 64'({16'd100, 5'd5, 6'd20, 6'd10}));
        host_set(6'd0, 6'd0, 5'd0, 16'd200, 1);
        do_tick();

        alarm_sec = 6'd0; alarm_min = 6'd1; alarm_hour = 5'd0;
        alarm_en = 1'b1;
        host_set(6'd59, 6'd0, 5'd0, 16'd1, 0);
        do_tick();
        alarm_en = 1'b0;
        host_set(6'd59, 6'd0, 5'd0, 16'd1, 0);
        do_tick();
        alarm_en = 1'b1;
        host_set(6'd0, 6'd1, 5'd0, 16'd1, 0);
        do_tick();
        alarm_en = 1'b0;

        bus4.set_sec = 6'd59; bus4.set_min = 6'd59; bus4.set_hour = 5'd23; bus4.set_day = 4'd15;
        bus4.set_req = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            step();
            if (bus4.set_ack) lat = c;
        end
        chk("w4_lat", 64'(lat), 64'd3);
        bus4.set_req = 1'b0;
        step();
        do_tick();
        chk("day_wrap", 64'({day4, hour4, min4, sec4}), 64'({zero4, 5'd0, 6'd0, 6'd0}));
        chk("w4_alarm", 64'(alarm4), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
